// File: rtl/beacon_pkg.sv
// ============================================================================
// Module   : beacon_pkg
// Purpose  : Shared class codes, FSM state type and counter width.
// Revision : 1.0
// ============================================================================
`default_nettype none

package beacon_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_A    = 2'd1;
    localparam logic [1:0] CLS_B    = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2,
        LOSING    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/beacon_band_match.sv
// ============================================================================
// Module   : beacon_band_match
// Purpose  : Optional 2-tap averager (BEACON_AVG_EN) plus two-band classifier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module beacon_band_match #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BAND_A_MIN = WIDTH'(1),
    parameter logic [WIDTH-1:0] BAND_A_MAX = WIDTH'(2),
    parameter logic [WIDTH-1:0] BAND_B_MIN = WIDTH'(8),
    parameter logic [WIDTH-1:0] BAND_B_MAX = WIDTH'(12)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] freq_in,
    input  logic             freq_valid,
    output logic [1:0]       match
);
    import beacon_pkg::*;

    logic [WIDTH-1:0] x;

`ifdef BEACON_AVG_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        if (freq_valid) begin
            prev_d    = freq_in;
            prev_ok_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
        end
    end

    // Sum kept one bit wider so the carry survives the halving.
    assign sum = {1'b0, freq_in} + {1'b0, prev_q};
    assign x   = prev_ok_q ? WIDTH'(sum >> 1) : freq_in;
`else
    logic unused_avg;
    assign unused_avg = &{1'b0, clk, rst, freq_valid};
    assign x          = freq_in;
`endif

    // Band A is tested first so it wins where the bands overlap.
    always_comb begin
        match = CLS_NONE;
        if (x >= BAND_A_MIN && x <= BAND_A_MAX)
            match = CLS_A;
        else if (x >= BAND_B_MIN && x <= BAND_B_MAX)
            match = CLS_B;
    end

endmodule

`default_nettype wire

// File: rtl/beacon_classifier.sv
// ============================================================================
// Module   : beacon_classifier
// Purpose  : Debounced beacon identity from per-window edge counts.
//            Optional input averaging is enabled by defining BEACON_AVG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module beacon_classifier #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BAND_A_MIN = WIDTH'(1),
    parameter logic [WIDTH-1:0] BAND_A_MAX = WIDTH'(2),
    parameter logic [WIDTH-1:0] BAND_B_MIN = WIDTH'(8),
    parameter logic [WIDTH-1:0] BAND_B_MAX = WIDTH'(12),
    parameter int               CONFIRM_N  = 3,
    parameter int               LOSS_N     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] freq_in,
    input  logic             freq_valid,
    output logic [1:0]       beacon_class,
    output logic             class_valid,
    output logic             class_change
);
    import beacon_pkg::*;

    localparam logic [CNT_W-1:0] CONFIRM_TGT = CNT_W'(CONFIRM_N);
    localparam logic [CNT_W-1:0] LOSS_TGT    = CNT_W'(LOSS_N);

    logic [1:0] m;

    beacon_band_match #(
        .WIDTH      (WIDTH),
        .BAND_A_MIN (BAND_A_MIN),
        .BAND_A_MAX (BAND_A_MAX),
        .BAND_B_MIN (BAND_B_MIN),
        .BAND_B_MAX (BAND_B_MAX)
    ) u_match (
        .clk        (clk),
        .rst        (rst),
        .freq_in    (freq_in),
        .freq_valid (freq_valid),
        .match      (m)
    );

    state_t           state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [1:0]       class_q, class_d;
    logic             valid_q, valid_d;
    logic             change_q, change_d;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        miss_d   = miss_q;
        class_d  = class_q;
        change_d = 1'b0;
        if (freq_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (m != CLS_NONE) begin
                        cand_d = m;
                        if (CONFIRM_TGT == 8'd1) begin
                            state_d  = LOCKED;
                            class_d  = m;
                            change_d = 1'b1;
                        end else begin
                            state_d = CANDIDATE;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                CANDIDATE: begin
                    if (m == cand_q) begin
                        if (cnt_q + 8'd1 == CONFIRM_TGT) begin
                            state_d  = LOCKED;
                            class_d  = cand_q;
                            change_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (m != CLS_NONE) begin
                        cand_d = m;
                        cnt_d  = 8'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                LOCKED: begin
                    if (m != class_q) begin
                        if (LOSS_TGT == 8'd1) begin
                            state_d  = IDLE;
                            class_d  = CLS_NONE;
                            change_d = 1'b1;
                        end else begin
                            state_d = LOSING;
                            miss_d  = 8'd1;
                        end
                    end
                end
                LOSING: begin
                    if (m == class_q) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end else if (miss_q + 8'd1 == LOSS_TGT) begin
                        // Unlocking window is not reused as a new candidate.
                        state_d  = IDLE;
                        class_d  = CLS_NONE;
                        change_d = 1'b1;
                        miss_d   = '0;
                    end else begin
                        miss_d = miss_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        valid_d = (state_d == LOCKED) || (state_d == LOSING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= CLS_NONE;
            cnt_q    <= '0;
            miss_q   <= '0;
            class_q  <= CLS_NONE;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            class_q  <= class_d;
            valid_q  <= valid_d;
            change_q <= change_d;
        end
    end

    assign beacon_class = class_q;
    assign class_valid  = valid_q;
    assign class_change = change_q;

endmodule

`default_nettype wire

// File: tb/tb_beacon_classifier.sv
// ============================================================================
// Module   : tb_beacon_classifier
// Purpose  : Scoreboard bench for beacon_classifier (default and B_MIN=2 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_beacon_classifier;

    typedef struct {
        int         sel;
        logic [1:0] cls;
        logic       vld;
        logic       chg;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] freq_in = '0;
    logic        freq_valid0 = 1'b0;
    logic        freq_valid1 = 1'b0;
    logic        chk = 1'b0;
    logic        chk_s = 1'b0;
    int          chk_sel = 0;
    int          chk_sel_s = 0;

    logic [1:0]  cls0, cls1;
    logic        vld0, vld1, chg0, chg1;
    logic        chg0_prev = 1'b0;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    beacon_classifier u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .freq_in      (freq_in),
        .freq_valid   (freq_valid0),
        .beacon_class (cls0),
        .class_valid  (vld0),
        .class_change (chg0)
    );

    beacon_classifier #(.BAND_B_MIN(32'd2)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .freq_in      (freq_in),
        .freq_valid   (freq_valid1),
        .beacon_class (cls1),
        .class_valid  (vld1),
        .class_change (chg1)
    );

    always @(posedge clk) begin
        chk_s     <= chk;
        chk_sel_s <= chk_sel;
    end

    // Monitor: one expected entry per checked cycle, compared half a cycle after the edge.
    always @(negedge clk) begin
        logic [3:0] act;
        logic [3:0] req;
        exp_t e;
        checks++;
        if (chg0 && chg0_prev) begin
            errors++;
            $display("FAIL change_twice: class_change high on two consecutive cycles");
        end
        chg0_prev = chg0;
        if (chk_s) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: output cycle with no expected entry");
            end else begin
                e   = q.pop_front();
                act = (e.sel == 0) ? {cls0, vld0, chg0} : {cls1, vld1, chg1};
                req = {e.cls, e.vld, e.chg};
                if (e.sel != chk_sel_s || act !== req) begin
                    errors++;
                    $display("FAIL %s: got class=%0d valid=%0b change=%0b, expected class=%0d valid=%0b change=%0b",
                             e.name, act[3:2], act[1], act[0], req[3:2], req[1], req[0]);
                end
            end
        end
    end

    task automatic step(input int sel, input logic r, input logic v, input logic [31:0] f,
                        input logic [1:0] ec, input logic ev, input logic eg, input string nm);
        exp_t e;
        @(negedge clk);
        rst         = r;
        freq_in     = f;
        freq_valid0 = v && (sel == 0);
        freq_valid1 = v && (sel == 1);
        chk         = 1'b1;
        chk_sel     = sel;
        e.sel  = sel;
        e.cls  = ec;
        e.vld  = ev;
        e.chg  = eg;
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a strobe present: strobe is discarded.
        step(0, 1, 1, 10, 0, 0, 0, "reset_cycle0");
        step(0, 1, 1, 10, 0, 0, 0, "reset_cycle1");
        step(0, 0, 0, 10, 0, 0, 0, "after_release");
        // Lock on B.
        step(0, 0, 1, 10, 0, 0, 0, "lock_b_1");
        step(0, 0, 1, 10, 0, 0, 0, "lock_b_2");
        step(0, 0, 1, 10, 2, 1, 1, "lock_b_3");
        step(0, 0, 0, 10, 2, 1, 0, "lock_b_hold");
        // Single glitch is tolerated.
        step(0, 0, 1, 0,  2, 1, 0, "glitch_miss");
        step(0, 0, 1, 10, 2, 1, 0, "glitch_recover");
        // Unlock, then lock on A from scratch.
        step(0, 0, 1, 1,  2, 1, 0, "unlock_1");
        step(0, 0, 1, 1,  0, 0, 1, "unlock_2");
        step(0, 0, 1, 1,  0, 0, 0, "switch_a_1");
        step(0, 0, 1, 1,  0, 0, 0, "switch_a_2");
        step(0, 0, 1, 1,  1, 1, 1, "switch_a_3");
        step(0, 0, 1, 0,  1, 1, 0, "drop_a_1");
        step(0, 0, 1, 0,  0, 0, 1, "drop_a_2");
        // Candidate interrupted by the other class.
        step(0, 0, 1, 10, 0, 0, 0, "interrupt_1");
        step(0, 0, 1, 10, 0, 0, 0, "interrupt_2");
        step(0, 0, 1, 1,  0, 0, 0, "interrupt_3");
        step(0, 0, 1, 10, 0, 0, 0, "interrupt_4");
        step(0, 0, 1, 10, 0, 0, 0, "interrupt_5");
        step(0, 0, 1, 10, 2, 1, 1, "interrupt_6");
        // Upper bits must not alias into band B.
        step(0, 0, 1, 32'h8000_000A, 2, 1, 0, "wide_miss");
        step(0, 0, 1, 10, 2, 1, 0, "wide_recover");
        // Just above band B.
        step(0, 0, 1, 13, 2, 1, 0, "b_max_plus1_1");
        step(0, 0, 1, 13, 0, 0, 1, "b_max_plus1_2");
        // Just above band A: never a class.
        step(0, 0, 1, 3,  0, 0, 0, "a_max_plus1_1");
        step(0, 0, 1, 3,  0, 0, 0, "a_max_plus1_2");
        step(0, 0, 1, 3,  0, 0, 0, "a_max_plus1_3");
        // Band B upper edge, with an idle gap inside the candidate run.
        step(0, 0, 1, 12, 0, 0, 0, "b_max_1");
        step(0, 0, 0, 12, 0, 0, 0, "b_max_gap");
        step(0, 0, 1, 12, 0, 0, 0, "b_max_2");
        step(0, 0, 1, 12, 2, 1, 1, "b_max_3");
        // Reset while locked clears without a change pulse.
        step(0, 1, 1, 12, 0, 0, 0, "reset_locked");
        step(0, 0, 0, 12, 0, 0, 0, "reset_locked_release");
        // Overlapping bands: A has priority.
        step(1, 0, 1, 2,  0, 0, 0, "overlap_1");
        step(1, 0, 1, 2,  0, 0, 0, "overlap_2");
        step(1, 0, 1, 2,  1, 1, 1, "overlap_3");

        @(negedge clk);
        chk         = 1'b0;
        freq_valid0 = 1'b0;
        freq_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
